// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle slave memory: word-organised RAM with byte-lane writes
// and a fixed number of wait states between request sample and ACK.
module wb_mem_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 0,
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ADR,
    input  logic [XLEN/8-1:0] SEL,
    input  logic              WE,
    input  logic              STB,
    input  logic              CYC,
    input  logic [XLEN-1:0]   DAT_W,
    output logic [XLEN-1:0]   DAT_R,
    output logic              ACK
);
    localparam int NB  = XLEN / 8;
    localparam int LSB = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [XLEN-1:0] BASE    = BASE_ADDR[XLEN-1:0];
    localparam logic [3:0]      WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            do_access;
    logic            access;
    logic            req;
    logic [XLEN-1:0] offset;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic            wr_en;
    logic            rd_en;
    logic [NB-1:0]   lane_we;
    logic [XLEN-1:0] dat_r_reg;
    logic [XLEN-1:0] mem [DEPTH];

    assign req = CYC & STB;

    // Unsigned subtraction: addresses below the base wrap high and land out of range.
    assign offset   = ADR - BASE;
    assign in_range = ((offset >> (AW + LSB)) == '0);
    assign idx      = offset[LSB +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_access  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_ACK;
                        do_access  = 1'b1;
                    end else begin
                        cnt_next   = WS_LOAD;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ST_ACK;
                    do_access  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The RAM has no reset, so an edge that arrives while reset is held must not commit.
    assign access = do_access & rst_n;
    assign wr_en  = access & WE & in_range;
    assign rd_en  = access & ~WE;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = wr_en & SEL[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (lane_we[k]) begin
                mem[idx][k*8 +: 8] <= DAT_W[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_r_reg <= '0;
        end else if (rd_en) begin
            dat_r_reg <= in_range ? mem[idx] : '0;
        end
    end

    assign DAT_R = dat_r_reg;
    assign ACK   = (state_reg == ST_ACK);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (0, 3 and 2 wait states) on a shared
// bus, an abstract latency/memory model checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_wb_mem_responder;
    localparam int ND     = 3;
    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int base_of(input int d);
        return d * 32'h400;
    endfunction

    function automatic logic [31:0] pat(input int d, input int i);
        return {8'(d), 8'(i), 16'hA55A};
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        cyc [ND];
    logic        stb [ND];
    logic        ack [ND];
    logic [31:0] dat_r [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            wb_mem_responder #(
                .XLEN(32),
                .DEPTH(DEPTH),
                .WAIT_STATES(ws_of(gi)),
                .BASE_ADDR(64'(base_of(gi))),
                .INIT_FILE("")
            ) u_dut (
                .clk(clk),
                .rst_n(rst_n),
                .ADR(adr),
                .SEL(sel),
                .WE(we),
                .STB(stb[gi]),
                .CYC(cyc[gi]),
                .DAT_W(dat_w),
                .DAT_R(dat_r[gi]),
                .ACK(ack[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: ACK is due once a request has been seen on WAIT_STATES+1 consecutive
    // edges (the edge that ends an ACK cycle never counts); the access happens then.
    logic [31:0] mdl_mem   [ND][DEPTH];
    bit          mdl_known [ND][DEPTH];
    int          held      [ND];
    bit          exp_ack   [ND];
    logic [31:0] exp_dat   [ND];
    bit          dat_known [ND];

    task automatic model_access(input int d);
        logic [31:0] off;
        int          i;
        off = adr - 32'(base_of(d));
        if (off < 32'(NBYTES)) begin
            i = int'(off >> 2);
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (sel[k]) mdl_mem[d][i][k*8 +: 8] = dat_w[k*8 +: 8];
                if (sel == 4'hF) mdl_known[d][i] = 1'b1;
            end else begin
                exp_dat[d]   = mdl_mem[d][i];
                dat_known[d] = mdl_known[d][i];
            end
        end else if (!we) begin
            exp_dat[d]   = 32'd0;
            dat_known[d] = 1'b1;
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            held[d] = 0; exp_ack[d] = 1'b0; exp_dat[d] = 32'd0; dat_known[d] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mdl_mem[d][i] = 32'd0; mdl_known[d][i] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n) begin
                    held[d] = 0; exp_ack[d] = 1'b0; exp_dat[d] = 32'd0; dat_known[d] = 1'b1;
                end else if (exp_ack[d]) begin
                    exp_ack[d] = 1'b0;
                    held[d]    = 0;
                end else if (cyc[d] && stb[d]) begin
                    held[d]++;
                    if (held[d] == ws_of(d) + 1) begin
                        held[d]    = 0;
                        exp_ack[d] = 1'b1;
                        model_access(d);
                    end
                end else begin
                    held[d] = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, every instance.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n) begin
                    check($sformatf("reset_ack[%0d]", d), 32'(ack[d]), 32'd0);
                    check($sformatf("reset_dat[%0d]", d), dat_r[d], 32'd0);
                end else begin
                    check($sformatf("ack[%0d]", d), 32'(ack[d]), 32'(exp_ack[d]));
                    if (dat_known[d]) check($sformatf("dat_r[%0d]", d), dat_r[d], exp_dat[d]);
                end
            end
        end
    end

    task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] s, input logic w,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        adr = a; sel = s; we = w; dat_w = wd;
        for (int k = 0; k < ND; k++) begin
            cyc[k] = (k == d); stb[k] = (k == d);
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack[d] && lat < 40);
        if (!ack[d]) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout[%0d]: no ACK after %0d cycles, expected ACK", d, lat);
        end
        rd = dat_r[d];
    endtask

    task automatic bus_idle();
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] wv;
        int          lat;
        int          acks;
        int          prev_d;
        int          d;
        logic [31:0] a;

        rst_n = 1'b0; adr = 32'd0; sel = 4'd0; we = 1'b0; dat_w = 32'd0;
        for (int k = 0; k < ND; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("por_ack[%0d]", k), 32'(ack[k]), 32'd0);
            check($sformatf("por_dat[%0d]", k), dat_r[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word of every instance with a known pattern.
        for (int dd = 0; dd < ND; dd++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wv = pat(dd, i);
                if (dd == 0 && i == 0) wv = 32'hDEADBEEF;
                if (dd == 0 && i == 4) wv = 32'h11223344;
                xfer(dd, 32'(base_of(dd)) + 32'(i * 4), 4'hF, 1'b1, wv, rd, lat);
            end
            bus_idle();
        end

        // Zero-wait read of word 0.
        xfer(0, 32'h0, 4'h0, 1'b0, 32'd0, rd, lat);
        check("ws0_read_lat", 32'(lat), 32'd1);
        check("ws0_read_data", rd, 32'hDEADBEEF);
        bus_idle();
        @(posedge clk);
        #1;
        check("ws0_ack_single", 32'(ack[0]), 32'd0);

        // Partial-lane write, then back-to-back read of the same word.
        xfer(0, 32'h10, 4'b0101, 1'b1, 32'hAABBCCDD, rd, lat);
        check("lane_write_lat", 32'(lat), 32'd1);
        xfer(0, 32'h10, 4'hF, 1'b0, 32'd0, rd, lat);
        check("b2b_read_lat", 32'(lat), 32'd2);
        check("lane_merge", rd, 32'h11BB33DD);

        // SEL=0 write is acknowledged and changes nothing.
        xfer(0, 32'h1C, 4'h0, 1'b1, 32'hFFFFFFFF, rd, lat);
        xfer(0, 32'h1C, 4'hF, 1'b0, 32'd0, rd, lat);
        check("sel0_write", rd, pat(0, 7));
        bus_idle();

        // Three wait states.
        xfer(1, 32'h414, 4'hF, 1'b0, 32'd0, rd, lat);
        check("ws3_read_lat", 32'(lat), 32'd4);
        check("ws3_read_data", rd, 32'h0105A55A);
        bus_idle();

        // Abandon a write after two sampled edges.
        @(negedge clk);
        adr = 32'h418; sel = 4'hF; we = 1'b1; dat_w = 32'hFFFFFFFF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(posedge clk);
        bus_idle();
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack[1]) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        xfer(1, 32'h418, 4'hF, 1'b0, 32'd0, rd, lat);
        check("abort_no_write", rd, 32'h0106A55A);
        bus_idle();

        // Out of range, above and below the window, and no aliasing on writes.
        xfer(1, 32'h500, 4'hF, 1'b0, 32'd0, rd, lat);
        check("oor_read_above", rd, 32'd0);
        xfer(1, 32'h414, 4'hF, 1'b0, 32'd0, rd, lat);
        xfer(1, 32'h3FC, 4'hF, 1'b0, 32'd0, rd, lat);
        check("oor_read_below", rd, 32'd0);
        xfer(1, 32'h500, 4'hF, 1'b1, 32'h12345678, rd, lat);
        check("oor_write_lat", 32'(lat), 32'd5);
        xfer(1, 32'h400, 4'hF, 1'b0, 32'd0, rd, lat);
        check("oor_no_alias_ws3", rd, 32'h0100A55A);
        xfer(0, 32'h100, 4'hF, 1'b1, 32'h12345678, rd, lat);
        xfer(0, 32'h0, 4'hF, 1'b0, 32'd0, rd, lat);
        check("oor_no_alias_ws0", rd, 32'hDEADBEEF);
        bus_idle();

        // Reset while a write waits.
        @(negedge clk);
        adr = 32'h80C; sel = 4'hF; we = 1'b1; dat_w = 32'hCAFEF00D;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ack_drop", 32'(ack[2]), 32'd0);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack[2]) acks++;
        end
        check("rst_no_late_ack", 32'(acks), 32'd0);
        xfer(2, 32'h80C, 4'hF, 1'b0, 32'd0, rd, lat);
        check("rst_next_lat", 32'(lat), 32'd3);
        check("rst_no_write", rd, 32'h0203A55A);
        bus_idle();

        // Random stream; data and ACK timing are checked by the compare process.
        prev_d = -1;
        for (int t = 0; t < 1000; t++) begin
            d = ($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 2);
            if ($urandom_range(0, 15) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'(base_of(d)) - 32'd4
                                                : 32'(base_of(d)) + 32'(NBYTES) + 32'($urandom_range(0, 63) * 4);
            else
                a = 32'(base_of(d)) + 32'($urandom_range(0, DEPTH - 1) * 4);
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                bus_idle();
                prev_d = -1;
            end
            xfer(d, a, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, rd, lat);
            check($sformatf("rand_lat[%0d]", t), 32'(lat),
                  32'(ws_of(d) + ((prev_d == d) ? 2 : 1)));
            prev_d = d;
        end
        bus_idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
